// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - 32-entry register-busy scoreboard feeding a single forwarding issue slot
module issue_scoreboard #(
    parameter int PAYLOAD_W = 96,
    parameter int XLEN      = 64,
    parameter int PC_W      = 48
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 decoder_inst_valid,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           rd,
    input  logic                 src1_is_reg,
    input  logic                 src2_is_reg,
    input  logic                 need_to_wb,
    input  logic [XLEN-1:0]      src1,
    input  logic [XLEN-1:0]      src2,
    input  logic [PC_W-1:0]      decoder_pc_out,
    input  logic [PAYLOAD_W-1:0] ctrl_payload,
    output logic                 fifo_read_en,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [XLEN-1:0]      issue_src1,
    output logic [XLEN-1:0]      issue_src2,
    output logic [4:0]           issue_rd,
    output logic                 issue_need_to_wb,
    output logic [PC_W-1:0]      issue_pc,
    output logic [PAYLOAD_W-1:0] issue_payload,
    input  logic                 writeback_valid,
    input  logic [4:0]           writeback_rd,
    input  logic [XLEN-1:0]      writeback_data,
    input  logic                 flush_valid,
    output logic [31:0]          busy_vec,
    output logic [31:0]          stall_cycles
);

    logic [31:0]          busy_q, busy_d;
    logic [31:0]          stall_q, stall_d;
    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      src1_q, src1_d, src2_q, src2_d;
    logic [4:0]           rd_q, rd_d;
    logic                 nwb_q, nwb_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PAYLOAD_W-1:0] pay_q, pay_d;

    logic [31:0] wb_clr, eff_busy, set_vec;
    logic        hazard, slot_free, accept;

    // Writeback this cycle retires the hazard immediately; its data is forwarded into the slot.
    always_comb begin
        wb_clr = '0;
        if (writeback_valid && writeback_rd != 5'd0) wb_clr[writeback_rd] = 1'b1;
        eff_busy  = busy_q & ~wb_clr;
        hazard    = (src1_is_reg && rs1 != 5'd0 && eff_busy[rs1]) ||
                    (src2_is_reg && rs2 != 5'd0 && eff_busy[rs2]) ||
                    (need_to_wb  && rd  != 5'd0 && eff_busy[rd]);
        slot_free = !valid_q || issue_ready;
        accept    = decoder_inst_valid && !hazard && slot_free && !flush_valid;
        set_vec   = '0;
        if (accept && need_to_wb && rd != 5'd0) set_vec[rd] = 1'b1;
    end

    always_comb begin
        busy_d    = (busy_q & ~wb_clr) | set_vec;
        busy_d[0] = 1'b0;
        stall_d   = stall_q;
        if (decoder_inst_valid && (hazard || !slot_free) && !flush_valid && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
        valid_d = valid_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        rd_d    = rd_q;
        nwb_d   = nwb_q;
        pc_d    = pc_q;
        pay_d   = pay_q;
        if (accept) begin
            valid_d = 1'b1;
            src1_d  = (src1_is_reg && rs1 != 5'd0 && wb_clr[rs1]) ? writeback_data : src1;
            src2_d  = (src2_is_reg && rs2 != 5'd0 && wb_clr[rs2]) ? writeback_data : src2;
            rd_d    = rd;
            nwb_d   = need_to_wb;
            pc_d    = decoder_pc_out;
            pay_d   = ctrl_payload;
        end else if (flush_valid || (valid_q && issue_ready)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= '0;
            stall_q <= '0;
            valid_q <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            rd_q    <= '0;
            nwb_q   <= 1'b0;
            pc_q    <= '0;
            pay_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            rd_q    <= rd_d;
            nwb_q   <= nwb_d;
            pc_q    <= pc_d;
            pay_q   <= pay_d;
        end
    end

    assign fifo_read_en     = accept;
    assign issue_valid      = valid_q;
    assign issue_src1       = src1_q;
    assign issue_src2       = src2_q;
    assign issue_rd         = rd_q;
    assign issue_need_to_wb = nwb_q;
    assign issue_pc         = pc_q;
    assign issue_payload    = pay_q;
    assign busy_vec         = busy_q;
    assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed and randomized checks of issue_scoreboard against a reference model
module tb_issue_scoreboard;

    logic         clock = 1'b0;
    logic         reset;
    logic         dv, s1r, s2r, nwb, rdy, wbv, fl;
    logic [4:0]   rs1, rs2, rd, wbrd;
    logic [63:0]  src1, src2, wbd;
    logic [47:0]  pc;
    logic [95:0]  pay;

    logic         fifo_read_en, issue_valid, issue_need_to_wb;
    logic [63:0]  issue_src1, issue_src2;
    logic [4:0]   issue_rd;
    logic [47:0]  issue_pc;
    logic [95:0]  issue_payload;
    logic [31:0]  busy_vec, stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    bit           m_busy[32];
    bit           m_valid;
    logic [63:0]  m_s1, m_s2;
    logic [4:0]   m_rd;
    logic         m_nwb;
    logic [47:0]  m_pc;
    logic [95:0]  m_pay;
    longint       m_stall;

    logic [31:0]  snap;
    logic [47:0]  pc_snap;

    always #5 clock = ~clock;

    issue_scoreboard dut (
        .clock(clock), .reset(reset), .decoder_inst_valid(dv),
        .rs1(rs1), .rs2(rs2), .rd(rd), .src1_is_reg(s1r), .src2_is_reg(s2r),
        .need_to_wb(nwb), .src1(src1), .src2(src2), .decoder_pc_out(pc),
        .ctrl_payload(pay), .fifo_read_en(fifo_read_en), .issue_valid(issue_valid),
        .issue_ready(rdy), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_rd(issue_rd), .issue_need_to_wb(issue_need_to_wb), .issue_pc(issue_pc),
        .issue_payload(issue_payload), .writeback_valid(wbv), .writeback_rd(wbrd),
        .writeback_data(wbd), .flush_valid(fl), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hits(input logic [4:0] r);
        return wbv && wbrd == r && r != 5'd0;
    endfunction

    function automatic bit still_busy(input logic [4:0] r);
        return r != 5'd0 && m_busy[r] && !wb_hits(r);
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic clr_in();
        dv = 0; s1r = 0; s2r = 0; nwb = 0; rdy = 1; wbv = 0; fl = 0; reset = 0;
        rs1 = 0; rs2 = 0; rd = 0; wbrd = 0; src1 = 0; src2 = 0; wbd = 0; pc = 0; pay = 0;
    endtask

    task automatic set_inst(input logic [4:0] a, input bit ar, input logic [4:0] b, input bit br,
                            input logic [4:0] d, input bit dw);
        dv = 1; rs1 = a; s1r = ar; rs2 = b; s2r = br; rd = d; nwb = dw;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        pc = {$urandom, $urandom}; pay = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_wb(input logic [4:0] r, input logic [63:0] d);
        wbv = 1; wbrd = r; wbd = d;
    endtask

    // Evaluate the rules on the inputs held this cycle, check the pop, clock, then check state.
    task automatic step();
        bit hz, free, acc, stl;
        #1;
        hz   = (s1r && still_busy(rs1)) || (s2r && still_busy(rs2)) || (nwb && still_busy(rd));
        free = !m_valid || rdy;
        acc  = dv && !hz && free && !fl;
        stl  = dv && (hz || !free) && !fl;
        chk("fifo_read_en", fifo_read_en, acc);
        @(posedge clock);
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_valid = 0; m_s1 = 0; m_s2 = 0; m_rd = 0; m_nwb = 0; m_pc = 0; m_pay = 0; m_stall = 0;
        end else begin
            if (stl && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
            if (wbv && wbrd != 0) m_busy[wbrd] = 0;
            if (acc) begin
                m_valid = 1;
                m_s1  = (s1r && wb_hits(rs1)) ? wbd : src1;
                m_s2  = (s2r && wb_hits(rs2)) ? wbd : src2;
                m_rd  = rd; m_nwb = nwb; m_pc = pc; m_pay = pay;
                if (nwb && rd != 0) m_busy[rd] = 1;
            end else if (fl || (m_valid && rdy)) begin
                m_valid = 0;
            end
        end
        #1;
        chk("issue_valid", issue_valid, m_valid);
        chk("busy_vec", busy_vec, model_vec());
        chk("stall_cycles", stall_cycles, m_stall[31:0]);
        chk("issue_src1", issue_src1, m_s1);
        chk("issue_src2", issue_src2, m_s2);
        chk("issue_rd", issue_rd, m_rd);
        chk("issue_need_to_wb", issue_need_to_wb, m_nwb);
        chk("issue_pc", issue_pc, m_pc);
        chk("issue_payload", issue_payload, m_pay);
    endtask

    initial begin
        clr_in();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_valid = 0; m_s1 = 0; m_s2 = 0; m_rd = 0; m_nwb = 0; m_pc = 0; m_pay = 0; m_stall = 0;

        reset = 1; step(); step();
        clr_in();
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_valid", issue_valid, 1'b0);
        chk("rst_stall", stall_cycles, 32'h0);
        chk("rst_src1", issue_src1, 64'h0);
        chk("rst_fifo", fifo_read_en, 1'b0);

        // Independent stream
        for (int i = 1; i <= 3; i++) begin
            clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'(i), 1); step();
            chk("stream_valid", issue_valid, 1'b1);
        end
        chk("stream_busy", busy_vec, 32'h0000_000E);
        for (int i = 1; i <= 3; i++) begin clr_in(); set_wb(5'(i), 64'h0); step(); end
        chk("stream_drain", busy_vec, 32'h0);

        // RAW stall resolved by same-cycle writeback
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd5, 1); step();
        snap = stall_cycles;
        for (int i = 0; i < 3; i++) begin clr_in(); set_inst(5'd5, 1, 5'd0, 0, 5'd0, 0); step(); end
        chk("raw_stall_count", stall_cycles, snap + 32'd3);
        clr_in(); set_inst(5'd5, 1, 5'd0, 0, 5'd0, 0); set_wb(5'd5, 64'hDEAD); #1;
        chk("raw_accept", fifo_read_en, 1'b1);
        step();
        chk("raw_fwd", issue_src1, 64'hDEAD);
        chk("raw_busy5", busy_vec[5], 1'b0);

        // WAW, set wins over same-index clear
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd7, 1); step();
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd7, 1); set_wb(5'd7, 64'h1); step();
        chk("waw_busy7", busy_vec[7], 1'b1);
        chk("waw_rd", issue_rd, 5'd7);
        clr_in(); set_wb(5'd7, 64'h2); step();

        // Backpressure
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd9, 1); rdy = 0; step();
        pc_snap = issue_pc;
        clr_in(); set_inst(5'd1, 1, 5'd2, 1, 5'd10, 1); rdy = 0; step(); step();
        chk("bp_pc_hold", issue_pc, pc_snap);
        rdy = 1; step();
        chk("bp_valid", issue_valid, 1'b1);
        chk("bp_rd", issue_rd, 5'd10);
        clr_in(); set_wb(5'd9, 64'h0); step();
        clr_in(); set_wb(5'd10, 64'h0); step();

        // x0 handling
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd0, 1); step();
        clr_in(); set_inst(5'd0, 1, 5'd0, 1, 5'd0, 0); #1;
        chk("x0_nostall", fifo_read_en, 1'b1);
        step();
        clr_in(); set_wb(5'd0, 64'h55); step();
        chk("x0_busy", busy_vec, 32'h0);

        // Flush then reset
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd4, 1); step();
        clr_in(); set_inst(5'd0, 0, 5'd0, 0, 5'd11, 1); rdy = 0; fl = 1; #1;
        chk("flush_fifo", fifo_read_en, 1'b0);
        step();
        chk("flush_valid", issue_valid, 1'b0);
        chk("flush_busy4", busy_vec[4], 1'b1);
        clr_in(); reset = 1; step();
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_stall", stall_cycles, 32'h0);

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            clr_in();
            if ($urandom_range(99) < 70)
                set_inst(5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)), 1'($urandom),
                         5'($urandom_range(7)), 1'($urandom));
            rdy = ($urandom_range(99) < 70);
            if ($urandom_range(1)) set_wb(5'($urandom_range(7)), {$urandom, $urandom});
            fl    = ($urandom_range(99) < 5);
            reset = ($urandom_range(99) < 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
